// File: rtl/asrm_regbank_seq.sv
// ASRM register bank (WR/SR/SP/PC + GP registers) with valid/ready commit sequencer.
// Optional macro ASRM_STACK_CHECK_EN enables SP bound checking and the FAULT state.

module asrm_regbank_seq #(
   parameter int                  wordsize    = 16,
   parameter int                  reg_count   = 16,
   parameter int                  idx_w       = $clog2(reg_count),
   parameter logic [wordsize-1:0] stack_base  = '0,
   parameter logic [wordsize-1:0] stack_limit = {wordsize{1'b1}}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [2:0]          op,
   input  logic [idx_w-1:0]    wr_index,
   input  logic [wordsize-1:0] wr_data,
   input  logic                stall,
   input  logic                resume,
   input  logic [idx_w-1:0]    rd_index,
   output logic [wordsize-1:0] rd_data,
   output logic [wordsize-1:0] wr_q,
   output logic [wordsize-1:0] sr_q,
   output logic [wordsize-1:0] sp_q,
   output logic [wordsize-1:0] pc_q,
   output logic                quit,
   output logic [1:0]          fault
);

   // state    | meaning
   // ST_RUN   | commits accepted when not stalled
   // ST_HALT  | QUIT seen; quit=1, waits for resume
   // ST_FAULT | stack bound violated; waits for resume, which clears fault
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_HALT  = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   localparam logic [2:0] OP_WRITE = 3'd1;
   localparam logic [2:0] OP_PUSH  = 3'd2;
   localparam logic [2:0] OP_POP   = 3'd3;
   localparam logic [2:0] OP_CALL  = 3'd4;
   localparam logic [2:0] OP_RET   = 3'd5;
   localparam logic [2:0] OP_QUIT  = 3'd6;

   localparam int NB   = wordsize / 8;
   localparam int INC4 = (NB < 4) ? NB : 4;
   localparam int INC2 = (NB < 2) ? NB : 2;

   localparam logic [idx_w-1:0] IDX_WR = idx_w'(0);
   localparam logic [idx_w-1:0] IDX_SR = idx_w'(1);
   localparam logic [idx_w-1:0] IDX_SP = idx_w'(2);
   localparam logic [idx_w-1:0] IDX_PC = idx_w'(3);

   if (!(wordsize == 8 || wordsize == 16 || wordsize == 32 || wordsize == 64)) begin : g_bad_wordsize
      $error("asrm_regbank_seq: wordsize must be 8, 16, 32 or 64");
   end
   if (reg_count < 8 || (reg_count & (reg_count - 1)) != 0) begin : g_bad_reg_count
      $error("asrm_regbank_seq: reg_count must be a power of two >= 8");
   end
   if (stack_limit < stack_base) begin : g_bad_stack
      $error("asrm_regbank_seq: stack_limit below stack_base");
   end

   logic [wordsize-1:0] regs_q [reg_count];
   logic [wordsize-1:0] regs_d [reg_count];
   logic [1:0]          state_q, state_d;

   logic                accept;
   logic                sp_up, sp_dn, sp_move, data_we;
   logic [wordsize-1:0] inc_data, inc_sel, sp_next;
   logic                stk_fault;

   assign op_ready = (state_q == ST_RUN) && !stall && !reset;
   assign accept   = op_valid && op_ready;

   assign sp_up   = (op == OP_PUSH) || (op == OP_CALL);
   assign sp_dn   = (op == OP_POP)  || (op == OP_RET);
   assign sp_move = sp_up || sp_dn;
   assign data_we = (op == OP_WRITE) || (op == OP_POP) || (op == OP_CALL) || (op == OP_RET);

   // SR[2:1] selects the data stack granule, capped at the word size
   always_comb begin
      inc_data = wordsize'(NB);
      case (regs_q[IDX_SR][2:1])
         2'b00:   inc_data = wordsize'(NB);
         2'b01:   inc_data = wordsize'(INC4);
         2'b10:   inc_data = wordsize'(INC2);
         default: inc_data = wordsize'(1);
      endcase
   end

   assign inc_sel = ((op == OP_PUSH) || (op == OP_POP)) ? inc_data : wordsize'(NB);
   assign sp_next = sp_up ? (regs_q[IDX_SP] + inc_sel) : (regs_q[IDX_SP] - inc_sel);

`ifdef ASRM_STACK_CHECK_EN
   logic [wordsize:0] sp_sum, sp_floor;
   logic              ovf, unf;
   logic [1:0]        fault_q, fault_d;

   // one extra bit so the bound compare never aliases through wrap-around
   assign sp_sum    = {1'b0, regs_q[IDX_SP]} + {1'b0, inc_sel};
   assign sp_floor  = {1'b0, stack_base} + {1'b0, inc_sel};
   assign ovf       = sp_up && (sp_sum > {1'b0, stack_limit});
   assign unf       = sp_dn && ({1'b0, regs_q[IDX_SP]} < sp_floor);
   assign stk_fault = ovf || unf;
   assign fault     = fault_q;
`else
   assign stk_fault = 1'b0;
   assign fault     = 2'b00;
`endif

   always_comb begin
      regs_d  = regs_q;
      state_d = state_q;
`ifdef ASRM_STACK_CHECK_EN
      fault_d = fault_q;
`endif
      case (state_q)
         ST_HALT: begin
            if (resume) state_d = ST_RUN;
         end
         ST_FAULT: begin
            if (resume) begin
               state_d = ST_RUN;
`ifdef ASRM_STACK_CHECK_EN
               fault_d = 2'b00;
`endif
            end
         end
         default: begin
            if (accept && stk_fault) begin
               state_d = ST_FAULT;
`ifdef ASRM_STACK_CHECK_EN
               fault_d = fault_q | {unf, ovf};
`endif
            end else if (accept) begin
               // SP arithmetic owns index SP; a same-cycle data write there is dropped
               if (data_we && !(sp_move && wr_index == IDX_SP)) regs_d[wr_index] = wr_data;
               if (sp_move) regs_d[IDX_SP] = sp_next;
               if (!(data_we && wr_index == IDX_PC))
                  regs_d[IDX_PC] = regs_q[IDX_PC] + wordsize'(1);
               if (op == OP_QUIT) state_d = ST_HALT;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < reg_count; i++)
            regs_q[i] <= (i == 2) ? stack_base : '0;
         state_q <= ST_RUN;
`ifdef ASRM_STACK_CHECK_EN
         fault_q <= 2'b00;
`endif
      end else begin
         regs_q  <= regs_d;
         state_q <= state_d;
`ifdef ASRM_STACK_CHECK_EN
         fault_q <= fault_d;
`endif
      end
   end

   assign rd_data = regs_q[rd_index];
   assign wr_q    = regs_q[IDX_WR];
   assign sr_q    = regs_q[IDX_SR];
   assign sp_q    = regs_q[IDX_SP];
   assign pc_q    = regs_q[IDX_PC];
   assign quit    = (state_q == ST_HALT);

endmodule

// File: tb/tb_asrm_regbank_seq.sv
// Bench for asrm_regbank_seq: directed table, hand sequences, and random ops vs a reference model.
// Expectations follow ASRM_STACK_CHECK_EN when it is defined for the build.

module tb_asrm_regbank_seq;
   localparam int          W     = 32;
   localparam logic [31:0] BASE  = 32'd0;
   localparam logic [31:0] LIMIT = 32'd64;

   localparam logic [2:0] NOP = 3'd0, WRT = 3'd1, PUSH = 3'd2, POP = 3'd3,
                          CALL = 3'd4, RET = 3'd5, QUIT = 3'd6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, op_valid, op_ready, stall, resume, quit;
   logic [2:0]  op;
   logic [3:0]  wr_index, rd_index;
   logic [31:0] wr_data, rd_data, wr_q, sr_q, sp_q, pc_q;
   logic [1:0]  fault;

   logic        b_reset, b_op_valid, b_op_ready, b_stall, b_resume, b_quit;
   logic [2:0]  b_op;
   logic [3:0]  b_wr_index, b_rd_index;
   logic [15:0] b_wr_data, b_rd_data, b_wr_q, b_sr_q, b_sp_q, b_pc_q;
   logic [1:0]  b_fault;

   asrm_regbank_seq #(.wordsize(32), .reg_count(16), .stack_base(BASE), .stack_limit(LIMIT)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op(op),
      .wr_index(wr_index), .wr_data(wr_data), .stall(stall), .resume(resume),
      .rd_index(rd_index), .rd_data(rd_data), .wr_q(wr_q), .sr_q(sr_q), .sp_q(sp_q),
      .pc_q(pc_q), .quit(quit), .fault(fault));

   asrm_regbank_seq #(.wordsize(16), .reg_count(16), .stack_base(16'h0100), .stack_limit(16'h0102)) dut16 (
      .clk(clk), .reset(b_reset), .op_valid(b_op_valid), .op_ready(b_op_ready), .op(b_op),
      .wr_index(b_wr_index), .wr_data(b_wr_data), .stall(b_stall), .resume(b_resume),
      .rd_index(b_rd_index), .rd_data(b_rd_data), .wr_q(b_wr_q), .sr_q(b_sr_q), .sp_q(b_sp_q),
      .pc_q(b_pc_q), .quit(b_quit), .fault(b_fault));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // reference model: register file as an array, mode 0=run 1=halt 2=fault
   logic [31:0] m_reg [16];
   int          m_mode;
   logic [1:0]  m_fault;

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = 32'd0;
      m_reg[2] = BASE;
      m_mode   = 0;
      m_fault  = 2'b00;
   endtask

   task automatic m_step(input bit rst, input bit v, input logic [2:0] o, input int idx,
                         input logic [31:0] d, input bit st, input bit rs);
      longint sp, nsp;
      int     nb, cap, inc;
      bit     writes, moves, up;
      if (rst) begin m_reset(); return; end
      if (m_mode == 1) begin if (rs) m_mode = 0; return; end
      if (m_mode == 2) begin if (rs) begin m_mode = 0; m_fault = 2'b00; end return; end
      if (!(v && !st)) return;
      nb = W / 8;
      case (m_reg[1][2:1])
         2'd0:    cap = nb;
         2'd1:    cap = 4;
         2'd2:    cap = 2;
         default: cap = 1;
      endcase
      inc    = (cap < nb) ? cap : nb;
      writes = (o == WRT) || (o == POP) || (o == CALL) || (o == RET);
      moves  = (o == PUSH) || (o == POP) || (o == CALL) || (o == RET);
      up     = (o == PUSH) || (o == CALL);
      if (o == CALL || o == RET) inc = nb;
      sp  = longint'(m_reg[2]);
      nsp = up ? sp + inc : sp - inc;
`ifdef ASRM_STACK_CHECK_EN
      if (moves && up && nsp > longint'(LIMIT)) begin m_fault[0] = 1'b1; m_mode = 2; return; end
      if (moves && !up && nsp < longint'(BASE)) begin m_fault[1] = 1'b1; m_mode = 2; return; end
`endif
      if (writes && !(moves && idx == 2)) m_reg[idx] = d;
      if (moves) m_reg[2] = nsp[31:0];
      if (!(writes && idx == 3)) m_reg[3] = m_reg[3] + 32'd1;
      if (o == QUIT) m_mode = 1;
   endtask

   task automatic drive(input bit rst, input bit v, input logic [2:0] o, input int idx,
                        input logic [31:0] d, input bit st, input bit rs, input int ridx);
      reset = rst; op_valid = v; op = o; wr_index = 4'(idx); wr_data = d;
      stall = st; resume = rs; rd_index = 4'(ridx);
      #2;
   endtask

   task automatic drive16(input bit rst, input bit v, input logic [2:0] o, input int idx,
                          input logic [15:0] d, input bit rs);
      b_reset = rst; b_op_valid = v; b_op = o; b_wr_index = 4'(idx); b_wr_data = d;
      b_stall = 1'b0; b_resume = rs; b_rd_index = 4'd5;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          v;
      logic [2:0]  op;
      int          idx;
      logic [31:0] data;
      int          ridx;
      logic [31:0] e_rd;
      logic [31:0] e_sp;
      logic [31:0] e_pc;
   } vec_t;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{1'b1, WRT,  5, 32'h1234, 5, 32'h1234, 32'd0,  32'h1};
      tbl[1]  = '{1'b1, WRT,  1, 32'h2,    1, 32'h2,    32'd0,  32'h2};
      tbl[2]  = '{1'b1, PUSH, 7, 32'hdead, 7, 32'h0,    32'd4,  32'h3};
      tbl[3]  = '{1'b1, PUSH, 7, 32'hbeef, 7, 32'h0,    32'd8,  32'h4};
      tbl[4]  = '{1'b1, WRT,  1, 32'h6,    1, 32'h6,    32'd8,  32'h5};
      tbl[5]  = '{1'b1, POP,  6, 32'h77,   6, 32'h77,   32'd7,  32'h6};
      tbl[6]  = '{1'b1, WRT,  3, 32'h40,   3, 32'h40,   32'd7,  32'h40};
      tbl[7]  = '{1'b1, NOP,  3, 32'h99,   3, 32'h41,   32'd7,  32'h41};
      tbl[8]  = '{1'b1, CALL, 8, 32'haa,   8, 32'haa,   32'd11, 32'h42};
      tbl[9]  = '{1'b1, RET,  2, 32'h999,  2, 32'd7,    32'd7,  32'h43};
      tbl[10] = '{1'b1, POP,  3, 32'h200,  3, 32'h200,  32'd6,  32'h200};
      tbl[11] = '{1'b0, WRT,  5, 32'hffff, 5, 32'h1234, 32'd6,  32'h200};

      drive16(1'b1, 1'b0, NOP, 0, 16'h0, 1'b0);
      drive(1'b1, 1'b1, WRT, 4, 32'h5a5a, 1'b0, 1'b0, 4);
      chk("reset op_ready", op_ready, 1'b0);
      tick();
      tick();
      chk("reset sp", sp_q, BASE);
      chk("reset pc", pc_q, 32'h0);
      chk("reset rd4", rd_data, 32'h0);
      chk("reset quit", quit, 1'b0);
      chk("reset fault", fault, 2'b00);

      for (int i = 0; i < 12; i++) begin
         drive(1'b0, tbl[i].v, tbl[i].op, tbl[i].idx, tbl[i].data, 1'b0, 1'b0, tbl[i].ridx);
         chk($sformatf("tbl%0d op_ready", i), op_ready, 1'b1);
         tick();
         chk($sformatf("tbl%0d rd", i), rd_data, tbl[i].e_rd);
         chk($sformatf("tbl%0d sp", i), sp_q, tbl[i].e_sp);
         chk($sformatf("tbl%0d pc", i), pc_q, tbl[i].e_pc);
      end

      // stall holds everything; the op goes in on the first unstalled cycle
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, WRT, 9, 32'h55, 1'b1, 1'b0, 9);
         chk("stall op_ready", op_ready, 1'b0);
         tick();
         chk("stall rd9", rd_data, 32'h0);
         chk("stall pc", pc_q, 32'h200);
      end
      drive(1'b0, 1'b1, WRT, 9, 32'h55, 1'b0, 1'b0, 9);
      chk("unstall op_ready", op_ready, 1'b1);
      tick();
      chk("unstall rd9", rd_data, 32'h55);
      chk("unstall pc", pc_q, 32'h201);
      drive(1'b0, 1'b0, WRT, 9, 32'h55, 1'b0, 1'b0, 9);
      tick();
      chk("once pc", pc_q, 32'h201);

      drive(1'b0, 1'b1, QUIT, 0, 32'h0, 1'b0, 1'b0, 9);
      tick();
      chk("quit quit", quit, 1'b1);
      chk("quit pc", pc_q, 32'h202);
      drive(1'b0, 1'b1, WRT, 9, 32'h66, 1'b0, 1'b0, 9);
      chk("halt op_ready", op_ready, 1'b0);
      tick();
      chk("halt rd9", rd_data, 32'h55);
      chk("halt pc", pc_q, 32'h202);
      chk("halt quit", quit, 1'b1);
      drive(1'b0, 1'b0, NOP, 0, 32'h0, 1'b0, 1'b1, 9);
      tick();
      chk("resume quit", quit, 1'b0);
      drive(1'b0, 1'b1, WRT, 10, 32'h7, 1'b0, 1'b0, 10);
      chk("resume op_ready", op_ready, 1'b1);
      tick();
      chk("resume rd10", rd_data, 32'h7);
      chk("resume pc", pc_q, 32'h203);
      drive(1'b0, 1'b1, WRT, 11, 32'h8, 1'b0, 1'b1, 11);
      tick();
      chk("run resume rd11", rd_data, 32'h8);
      chk("run resume pc", pc_q, 32'h204);
      chk("run resume quit", quit, 1'b0);

      drive(1'b1, 1'b1, WRT, 12, 32'h9, 1'b0, 1'b1, 12);
      chk("rstprio op_ready", op_ready, 1'b0);
      tick();
      chk("rstprio rd12", rd_data, 32'h0);
      chk("rstprio pc", pc_q, 32'h0);
      chk("rstprio sp", sp_q, BASE);
      m_reset();

      // 16-bit instance with a two-byte stack window
      tick();
      drive16(1'b0, 1'b1, PUSH, 0, 16'h0, 1'b0);
      chk("b push op_ready", b_op_ready, 1'b1);
      tick();
      chk("b push sp", b_sp_q, 16'h0102);
      drive16(1'b0, 1'b1, CALL, 5, 16'h11, 1'b0);
      tick();
      drive16(1'b0, 1'b0, NOP, 0, 16'h0, 1'b0);
`ifdef ASRM_STACK_CHECK_EN
      chk("b ovf sp", b_sp_q, 16'h0102);
      chk("b ovf fault", b_fault, 2'b01);
      chk("b ovf op_ready", b_op_ready, 1'b0);
      chk("b ovf pc", b_pc_q, 16'h1);
`else
      chk("b call sp", b_sp_q, 16'h0104);
      chk("b call fault", b_fault, 2'b00);
      chk("b call op_ready", b_op_ready, 1'b1);
      chk("b call pc", b_pc_q, 16'h2);
`endif
      drive16(1'b0, 1'b0, NOP, 0, 16'h0, 1'b1);
      tick();
      drive16(1'b0, 1'b0, NOP, 0, 16'h0, 1'b0);
      chk("b resume fault", b_fault, 2'b00);
      chk("b resume op_ready", b_op_ready, 1'b1);
      drive16(1'b1, 1'b0, NOP, 0, 16'h0, 1'b0);
      tick();
      drive16(1'b0, 1'b1, RET, 5, 16'h33, 1'b0);
      tick();
      drive16(1'b0, 1'b0, NOP, 0, 16'h0, 1'b0);
`ifdef ASRM_STACK_CHECK_EN
      chk("b unf sp", b_sp_q, 16'h0100);
      chk("b unf fault", b_fault, 2'b10);
      chk("b unf rd5", b_rd_data, 16'h0);
      chk("b unf pc", b_pc_q, 16'h0);
`else
      chk("b ret sp", b_sp_q, 16'h00fe);
      chk("b ret fault", b_fault, 2'b00);
      chk("b ret rd5", b_rd_data, 16'h33);
      chk("b ret pc", b_pc_q, 16'h1);
`endif

      for (int n = 0; n < 800; n++) begin
         bit          r, v, st, rs;
         logic [2:0]  o;
         int          idx, ridx;
         logic [31:0] d;
         r    = ($urandom_range(0, 59) == 0);
         v    = ($urandom_range(0, 9) < 7);
         st   = ($urandom_range(0, 3) == 0);
         rs   = ($urandom_range(0, 4) == 0);
         o    = 3'($urandom_range(0, 7));
         idx  = $urandom_range(0, 15);
         ridx = $urandom_range(0, 15);
         d    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 80));
         drive(r, v, o, idx, d, st, rs, ridx);
         chk("rnd op_ready", op_ready, (!r && m_mode == 0 && !st));
         @(posedge clk);
         m_step(r, v, o, idx, d, st, rs);
         #1;
         chk("rnd rd", rd_data, m_reg[ridx]);
         chk("rnd wr", wr_q, m_reg[0]);
         chk("rnd sr", sr_q, m_reg[1]);
         chk("rnd sp", sp_q, m_reg[2]);
         chk("rnd pc", pc_q, m_reg[3]);
         chk("rnd quit", quit, (m_mode == 1));
         chk("rnd fault", fault, m_fault);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/asrm_regbank_seq.md
Name: asrm_regbank_seq

Overview:
- Parametrised register bank and commit sequencer for the ASRM core; holds WR, SR, SP, PC and the general-purpose registers.
- Generalises register count and word size, and adds a valid/ready commit handshake, a RUN/HALT/FAULT state machine and stack-bound checking.
- Sits between the ALU/address units, which supply write index and data, and the core top, which drives commit requests.

Parameters:
wordsize, 16, register width in bits; 8/16/32/64 only
reg_count, 16, number of registers; power of two, >=8
idx_w, $clog2(reg_count), register index width (derived)
stack_base, 0, lowest legal SP value; SP reset value
stack_limit, 2**wordsize-1, highest legal SP value

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
op_valid  in  1  commit request present
op_ready  out  1  commit may be accepted this cycle
op  in  3  0 NOP, 1 WRITE, 2 PUSH, 3 POP, 4 CALL, 5 RET, 6 QUIT
wr_index  in  idx_w  destination register
wr_data  in  wordsize  destination value
stall  in  1  bus not ready; blocks acceptance
resume  in  1  leave HALT/FAULT back to RUN
rd_index  in  idx_w  combinational read select
rd_data  out  wordsize  registers[rd_index]
wr_q, sr_q, sp_q, pc_q  out  wordsize each  special register contents
quit  out  1  high in HALT
fault  out  2  bit0 stack overflow, bit1 underflow; sticky

Behaviour:
- Fixed indices: WR=0, SR=1, SP=2, PC=3; GP = 4..reg_count-1.
- Reset (synchronous, active-high): every register 0 except SP=stack_base; state RUN; quit=0; fault=0; op_ready=0 during the reset cycle.
- op_ready = (state==RUN) && !stall && !reset. Accept = op_valid && op_ready. Nothing changes without accept.
- Data increment inc_d from SR[2:1]: 00 -> wordsize/8; 01 -> min(4, wordsize/8); 10 -> min(2, wordsize/8); 11 -> 1.
- Address increment inc_a = wordsize/8 always.
- On accept, results are visible the next cycle (latency 1):
  - NOP: no register write.
  - WRITE: reg[wr_index] <= wr_data.
  - PUSH: SP += inc_d; no other write.
  - POP: SP -= inc_d; reg[wr_index] <= wr_data.
  - CALL: SP += inc_a; reg[wr_index] <= wr_data.
  - RET: SP -= inc_a; reg[wr_index] <= wr_data.
  - QUIT: state -> HALT; no register write.
- PC update on accept: PC += 1 (mod 2^wordsize) unless the op writes index PC. If so, wr_data wins and there is no increment.
- SP update wins over a same-cycle wr_index==SP write. The data write is dropped.
- Stack check, computed at full wordsize+1 precision:
  - Overflow: PUSH/CALL with SP+inc > stack_limit.
  - Underflow: POP/RET with SP-inc < stack_base.
  - On fault: no register or PC change, fault bit set, state -> FAULT.
- States:
  - RUN: accepts ops.
  - HALT: quit=1, no accepts; resume -> RUN and quit clears next cycle.
  - FAULT: no accepts; resume -> RUN, fault cleared.
  - reset from any state -> RUN.
- resume is ignored in RUN. Reset has priority over resume, stall and op_valid.
- stall held high: op_ready low; state and registers hold. An op presented during stall is accepted on the first cycle stall is low.

Optional Feature:
- Macro: ASRM_STACK_CHECK_EN.
- Defined: bound checking and the FAULT state exist as described.
- Undefined:
  - No checks; SP wraps modulo 2^wordsize.
  - fault is tied to 0 and FAULT is unreachable.
  - stack_base is still the SP reset value.

Test Plan:
- Reset, then WRITE idx 5 = 0x1234 -> next cycle rd_data(5)=0x1234, pc_q=1, sp_q=stack_base.
- wordsize=32, SR=0b010 (01), PUSH twice -> sp_q=8; SR=0b110 (11), POP -> sp_q=7 with reg written.
- WRITE idx 3 = 0x0040 -> pc_q=0x0040, not 0x0041; then NOP -> pc_q=0x0041.
- stall=1 for 3 cycles with op_valid=1 -> op_ready=0 and no state change; stall=0 -> op accepted once.
- QUIT -> quit=1 and op_ready=0; resume=1 -> quit=0 and ops accepted again.
- With ASRM_STACK_CHECK_EN, stack_limit=stack_base+2, wordsize=16: PUSH, then CALL -> fault=01, sp_q=stack_base+2, state FAULT. Without the macro, the same sequence gives sp_q=stack_base+4 and fault=0.
